pipe_hazard_unit: RTL and testbench

- Parametrised successor to the fixed 2-port, 3-stage forwarding/load-use logic in the 16-bit pipelined CPU.
- Keeps its own shadow scoreboard of in-flight writers (EX..WB), selects per-read-port forwarding data and generates stall/bubble.
- Load-use stall length is set by LOAD_LAT. Supports flush on branch resolution and a global freeze on cache miss.
- Sits between ID and the ID/EX flops.

---
 rtl/pipe_hazard_unit.sv | 102 ++++++++++
 tb/tb_pipe_hazard_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Forwarding and load-use hazard unit between ID and the ID/EX flops, with a shadow scoreboard of in-flight writers.
// Optional performance counters are built when HZD_PERF_CNT_EN is defined.
module pipe_hazard_unit #(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 4,
  parameter int NUM_RD   = 2,
  parameter int NUM_STG  = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(NUM_STG + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       id_valid,
  input  logic                       id_wr_en,
  input  logic [REG_AW-1:0]          id_wr_reg,
  input  logic                       id_is_load,
  input  logic [NUM_RD-1:0]          id_rd_en,
  input  logic [NUM_RD*REG_AW-1:0]   id_rd_reg,
  input  logic [NUM_RD*DATA_W-1:0]   rf_data,
  input  logic [NUM_STG*DATA_W-1:0]  stg_data,
  output logic [NUM_RD*DATA_W-1:0]   fwd_data,
  output logic [NUM_RD*SEL_W-1:0]    fwd_sel,
  output logic                       stall,
  output logic                       bubble
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                fwd_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic              wr_en;
    logic [REG_AW-1:0] wr_reg;
    logic              is_load;
  } sb_entry_t;

  sb_entry_t         stg_q [NUM_STG];
  logic [NUM_RD-1:0] hazard;
  logic              kill_id;

  function automatic logic fwd_match(input sb_entry_t e, input logic rd_en,
                                     input logic [REG_AW-1:0] rd_reg);
    return e.valid && e.wr_en && rd_en && (rd_reg != '0) && (e.wr_reg == rd_reg);
  endfunction

  // Scan oldest to youngest so the youngest matching stage is the one left standing.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    fwd_sel  = '0;
    fwd_data = rf_data;
    hazard   = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      for (int i = NUM_STG - 1; i >= 0; i--) begin
        if (fwd_match(stg_q[i], id_rd_en[p], id_rd_reg[p*REG_AW +: REG_AW])) begin
          fwd_sel[p*SEL_W +: SEL_W]   = SEL_W'(i + 1);
          fwd_data[p*DATA_W +: DATA_W] = stg_data[i*DATA_W +: DATA_W];
          hazard[p]                   = stg_q[i].is_load && (i < LOAD_LAT);
        end
      end
    end
  end

  assign stall   = id_valid && (|hazard) && !flush;
  assign kill_id = stall || flush || !id_valid;
  assign bubble  = kill_id && !freeze;

  // A held load keeps advancing while ID is stalled, so the stall clears itself after LOAD_LAT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is control state, so every entry is reset; a pure data array would not need it.
      for (int k = 0; k < NUM_STG; k++) stg_q[k] <= '0;
    end else if (!freeze) begin
      // NOTE: non-blocking assignments let each stage read the previous stage's old value.
      for (int k = NUM_STG - 1; k >= 2; k--) stg_q[k] <= stg_q[k-1];
      stg_q[1] <= flush ? sb_entry_t'('0) : stg_q[0];
      if (kill_id) begin
        stg_q[0] <= '0;
      end else begin
        stg_q[0] <= '{valid: 1'b1, wr_en: id_wr_en, wr_reg: id_wr_reg, is_load: id_is_load};
      end
    end
  end

`ifdef HZD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!freeze) begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (id_valid && (|fwd_sel) && !stall) fwd_cnt <= fwd_cnt + 32'd1;
    end
  end
`else
  // Counters are absent; the hazard and forwarding behaviour is identical.
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: default build (3 stages, LOAD_LAT=1) alongside a 4-stage, LOAD_LAT=2 instance.
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        id_valid;
  logic        id_wr_en;
  logic [3:0]  id_wr_reg;
  logic        id_is_load;
  logic [1:0]  id_rd_en;
  logic [7:0]  id_rd_reg;
  logic [31:0] rf_data;
  logic [47:0] stg_data;
  logic [63:0] stg_data2;

  logic [31:0] fwd_data,  fwd_data2;
  logic [3:0]  fwd_sel;
  logic [5:0]  fwd_sel2;
  logic        stall, stall2, bubble, bubble2;
`ifdef HZD_PERF_CNT_EN
  logic [31:0] stall_cnt, fwd_cnt, stall_cnt2, fwd_cnt2;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .id_rd_en(id_rd_en), .id_rd_reg(id_rd_reg), .rf_data(rf_data), .stg_data(stg_data),
    .fwd_data(fwd_data), .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble)
`ifdef HZD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
  );

  pipe_hazard_unit #(.NUM_STG(4), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_is_load(id_is_load),
    .id_rd_en(id_rd_en), .id_rd_reg(id_rd_reg), .rf_data(rf_data), .stg_data(stg_data2),
    .fwd_data(fwd_data2), .fwd_sel(fwd_sel2), .stall(stall2), .bubble(bubble2)
`ifdef HZD_PERF_CNT_EN
    , .stall_cnt(stall_cnt2), .fwd_cnt(fwd_cnt2)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic we, input logic [3:0] wr, input logic ld,
                        input logic [1:0] rden, input logic [3:0] r0, input logic [3:0] r1);
    id_valid   = v;
    id_wr_en   = we;
    id_wr_reg  = wr;
    id_is_load = ld;
    id_rd_en   = rden;
    id_rd_reg  = {r1, r0};
  endtask

  task automatic do_reset();
    set_id(1'b1, 1'b0, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0);
    freeze = 1'b0;
    flush  = 1'b0;
    rst    = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rf_data   = {16'hBEEF, 16'hF00D};
    stg_data  = {16'h00C2, 16'h1234, 16'h00AA};
    stg_data2 = {16'h0D33, 16'h00C2, 16'h1234, 16'h00AA};
    rst = 1'b0;
    #1;
    do_reset();

    // Reset state
    #1;
    check("rst_stall",  stall,    1'b0);
    check("rst_bubble", bubble,   1'b0);
    check("rst_sel",    fwd_sel,  4'h0);
    check("rst_data",   fwd_data, 32'hBEEF_F00D);

    // ALU back-to-back: ADD r3, then read r3 on port0, r7 on port1
    set_id(1'b1, 1'b1, 4'd3, 1'b0, 2'b00, 4'd0, 4'd0);
    #1;
    check("alu_issue_stall", stall, 1'b0);
    next_cycle();
    set_id(1'b1, 1'b0, 4'd0, 1'b0, 2'b11, 4'd3, 4'd7);
    #1;
    check("alu_sel0",   fwd_sel[1:0],    2'd1);
    check("alu_data0",  fwd_data[15:0],  16'h00AA);
    check("alu_sel1",   fwd_sel[3:2],    2'd0);
    check("alu_data1",  fwd_data[31:16], 16'hBEEF);
    check("alu_stall",  stall,  1'b0);
    check("alu_bubble", bubble, 1'b0);
    next_cycle();
    set_id(1'b1, 1'b0, 4'd0, 1'b0, 2'b10, 4'd0, 4'd3);
    #1;
    check("alu_mem_sel1",  fwd_sel[3:2],    2'd2);
    check("alu_mem_data1", fwd_data[31:16], 16'h1234);

    // Load-use: LW r5 then a reader of r5 (both instances)
    do_reset();
    set_id(1'b1, 1'b1, 4'd5, 1'b1, 2'b00, 4'd0, 4'd0);
    next_cycle();
    set_id(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd5, 4'd0);
    #1;
    check("lu_stall_c1",   stall,   1'b1);
    check("lu_bubble_c1",  bubble,  1'b1);
    check("lu2_stall_c1",  stall2,  1'b1);
    next_cycle();
    check("lu_stall_c2",   stall,          1'b0);
    check("lu_bubble_c2",  bubble,         1'b0);
    check("lu_sel_c2",     fwd_sel[1:0],   2'd2);
    check("lu_data_c2",    fwd_data[15:0], 16'h1234);
    check("lu2_stall_c2",  stall2,         1'b1);
    next_cycle();
    check("lu2_stall_c3",  stall2,          1'b0);
    check("lu2_sel_c3",    fwd_sel2[2:0],   3'd3);
    check("lu2_data_c3",   fwd_data2[15:0], 16'h00C2);

    // Priority and zero register: r2 in stage0 and stage2, r0 in stage1
    do_reset();
    set_id(1'b1, 1'b1, 4'd2, 1'b0, 2'b00, 4'd0, 4'd0);
    next_cycle();
    set_id(1'b1, 1'b1, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0);
    next_cycle();
    set_id(1'b1, 1'b1, 4'd2, 1'b0, 2'b00, 4'd0, 4'd0);
    next_cycle();
    set_id(1'b1, 1'b0, 4'd0, 1'b0, 2'b11, 4'd2, 4'd0);
    #1;
    check("pri_sel0",  fwd_sel[1:0],    2'd1);
    check("pri_data0", fwd_data[15:0],  16'h00AA);
    check("r0_sel1",   fwd_sel[3:2],    2'd0);
    check("r0_data1",  fwd_data[31:16], 16'hBEEF);
    id_rd_en = 2'b10;
    #1;
    check("rden_off_sel0", fwd_sel[1:0], 2'd0);

    // Flush during a pending load-use stall
    do_reset();
    set_id(1'b1, 1'b1, 4'd1, 1'b1, 2'b00, 4'd0, 4'd0);
    next_cycle();
    set_id(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd1, 4'd0);
    flush = 1'b1;
    #1;
    check("fl_stall",  stall,  1'b0);
    check("fl_bubble", bubble, 1'b1);
    next_cycle();
    flush = 1'b0;
    #1;
    check("fl_sel",    fwd_sel[1:0],   2'd0);
    check("fl_data",   fwd_data[15:0], 16'hF00D);
    check("fl_stall2", stall,          1'b0);
    check("fl2_sel",   fwd_sel2[2:0],  3'd0);

    // Freeze for 5 cycles with a hazard pending
    do_reset();
    set_id(1'b1, 1'b1, 4'd5, 1'b1, 2'b00, 4'd0, 4'd0);
    next_cycle();
    set_id(1'b1, 1'b0, 4'd0, 1'b0, 2'b01, 4'd5, 4'd0);
    freeze = 1'b1;
    #1;
    check("frz_stall_0",  stall,  1'b1);
    check("frz_bubble_0", bubble, 1'b0);
    for (int k = 1; k < 5; k++) begin
      next_cycle();
      check($sformatf("frz_stall_%0d", k), stall,        1'b1);
      check($sformatf("frz_sel_%0d", k),   fwd_sel[1:0], 2'd1);
    end
`ifdef HZD_PERF_CNT_EN
    check("frz_stall_cnt", stall_cnt, 32'd0);
    check("frz_fwd_cnt",   fwd_cnt,   32'd0);
`endif
    next_cycle();
    freeze = 1'b0;
    #1;
    check("unfrz_stall",  stall,  1'b1);
    check("unfrz_bubble", bubble, 1'b1);
    next_cycle();
    check("rel_stall",  stall,          1'b0);
    check("rel_sel",    fwd_sel[1:0],   2'd2);
    check("rel_data",   fwd_data[15:0], 16'h1234);
    check("rel2_stall", stall2,         1'b1);
    next_cycle();
    check("rel2_stall_c8", stall2,        1'b0);
    check("rel2_sel_c8",   fwd_sel2[2:0], 3'd3);
`ifdef HZD_PERF_CNT_EN
    check("cnt_stall",  stall_cnt,  32'd1);
    check("cnt_fwd",    fwd_cnt,    32'd1);
    check("cnt2_stall", stall_cnt2, 32'd2);
    check("cnt2_fwd",   fwd_cnt2,   32'd0);
`endif

    // Freeze overrides flush: state held, no bubble
    freeze = 1'b1;
    flush  = 1'b1;
    #1;
    check("frz_fl_bubble", bubble, 1'b0);
    next_cycle();
    check("frz_fl_sel", fwd_sel[1:0], 2'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
